// File: rtl/vx_commit_collector_pkg.sv
// Shared widths, packet layout and helpers for the per-issue-slot commit collector.
package vx_commit_collector_pkg;

   localparam int CC_NUM_UNITS   = 5;
   localparam int CC_NUM_THREADS = 4;
   localparam int CC_XLEN        = 32;
   localparam int CC_NW_BITS     = 2;
   localparam int CC_PC_BITS     = 32;
   localparam int CC_RD_BITS     = 5;
   localparam int CC_CNT_W       = $clog2(CC_NUM_THREADS) + 1;
   localparam int INSTRET_W      = 64;
   localparam int PKT_W          = CC_NW_BITS + CC_NUM_THREADS + CC_PC_BITS + 1 + CC_RD_BITS
                                   + CC_NUM_THREADS * CC_XLEN + 2;

   typedef struct packed {
      logic [CC_NW_BITS-1:0]             wid;
      logic [CC_NUM_THREADS-1:0]         tmask;
      logic [CC_PC_BITS-1:0]             pc;
      logic                              wb;
      logic [CC_RD_BITS-1:0]             rd;
      logic [CC_NUM_THREADS*CC_XLEN-1:0] data;
      logic                              sop;
      logic                              eop;
   } commit_pkt_t;

   // Writeback payload as held in the output register (the wb bit becomes wb_valid).
   typedef struct packed {
      logic [CC_NW_BITS-1:0]             wid;
      logic [CC_NUM_THREADS-1:0]         tmask;
      logic [CC_PC_BITS-1:0]             pc;
      logic [CC_RD_BITS-1:0]             rd;
      logic [CC_NUM_THREADS*CC_XLEN-1:0] data;
      logic                              sop;
      logic                              eop;
   } wb_out_t;

   function automatic logic [CC_CNT_W-1:0] popcount(input logic [CC_NUM_THREADS-1:0] mask);
      logic [CC_CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < CC_NUM_THREADS; i++) n = n + CC_CNT_W'(mask[i]);
      return n;
   endfunction

endpackage

// File: rtl/vx_commit_collector_arbiter.sv
// Round-robin arbiter whose grant stays locked to one requester for a multi-packet instruction.
module vx_rr_lock_arbiter #(
   parameter  int N  = 5,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  req,
   input  logic          grant_sop,
   input  logic          grant_eop,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          locked
);

   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IW-1:0] lock_idx_q, lock_idx_d;
   logic          locked_q, locked_d;
   logic          found;
   logic          fire;
   int            idx;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      grant     = '0;
      grant_idx = rr_ptr_q;
      found     = 1'b0;
      idx       = 0;
      if (locked_q) begin
         // A locked owner keeps the grant; an idle owner just blocks everyone else.
         grant_idx = lock_idx_q;
         found     = req[lock_idx_q];
      end else begin
         for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr_q) + k) % N;
            if (!found && req[idx]) begin
               found     = 1'b1;
               grant_idx = IW'(idx);
            end
         end
      end
      if (found && !reset) grant[grant_idx] = 1'b1;
      fire = |grant;

      rr_ptr_d   = rr_ptr_q;
      lock_idx_d = lock_idx_q;
      locked_d   = locked_q;
      if (fire) begin
         if (grant_eop) begin
            rr_ptr_d = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
            locked_d = 1'b0;
         end else if (grant_sop) begin
            locked_d   = 1'b1;
            lock_idx_d = grant_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state flops use non-blocking assignments so all flops sample pre-edge values.
      if (reset) begin
         rr_ptr_q   <= '0;
         lock_idx_q <= '0;
         locked_q   <= 1'b0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         lock_idx_q <= lock_idx_d;
         locked_q   <= locked_d;
      end
   end

   assign locked = locked_q;

endmodule

// File: rtl/vx_commit_collector.sv
// Per-issue-slot commit collector: arbitrates unit commit streams into one registered
// writeback stream and produces retire events plus the slot's instret count.
module vx_commit_collector
   import vx_commit_collector_pkg::*;
#(
   parameter int NUM_UNITS   = CC_NUM_UNITS,
   parameter int NUM_THREADS = CC_NUM_THREADS,
   parameter int XLEN        = CC_XLEN,
   parameter int NW_BITS     = CC_NW_BITS,
   parameter int PC_BITS     = CC_PC_BITS
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_UNITS-1:0]          in_valid,
   input  logic [NUM_UNITS*PKT_W-1:0]    in_pkt,
   output logic [NUM_UNITS-1:0]          in_ready,
   output logic                          wb_valid,
   output logic [NW_BITS-1:0]            wb_wid,
   output logic [NUM_THREADS-1:0]        wb_tmask,
   output logic [PC_BITS-1:0]            wb_PC,
   output logic [4:0]                    wb_rd,
   output logic [NUM_THREADS*XLEN-1:0]   wb_data,
   output logic                          wb_sop,
   output logic                          wb_eop,
   output logic                          retire_valid,
   output logic [NW_BITS-1:0]            retire_wid,
   output logic [$clog2(NUM_THREADS):0]  retire_cnt,
   output logic [INSTRET_W-1:0]          instret
);

   localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

   commit_pkt_t          pkt [NUM_UNITS];
   commit_pkt_t          sel;
   logic [NUM_UNITS-1:0] grant;
   logic [IDX_W-1:0]     grant_idx;
   logic                 locked;
   logic                 fire;

   for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unpack
      assign pkt[i] = in_pkt[i*PKT_W +: PKT_W];
   end

   assign sel = pkt[grant_idx];

   vx_rr_lock_arbiter #(.N(NUM_UNITS)) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (in_valid),
      .grant_sop (sel.sop),
      .grant_eop (sel.eop),
      .grant     (grant),
      .grant_idx (grant_idx),
      .locked    (locked)
   );

   assign in_ready = grant;
   assign fire     = |grant;

   logic                 wb_valid_q, wb_valid_d;
   wb_out_t              wb_out_q, wb_out_d;
   logic                 retire_valid_q, retire_valid_d;
   logic [NW_BITS-1:0]   retire_wid_q, retire_wid_d;
   logic [CC_CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
   logic [INSTRET_W-1:0] instret_q, instret_d;

   always_comb begin
      wb_valid_d     = fire & sel.wb;
      wb_out_d       = wb_out_q;
      retire_valid_d = fire & sel.eop;
      retire_wid_d   = retire_wid_q;
      retire_cnt_d   = retire_cnt_q;
      instret_d      = instret_q;
      if (wb_valid_d) begin
         wb_out_d = '{wid: sel.wid, tmask: sel.tmask, pc: sel.pc, rd: sel.rd,
                      data: sel.data, sop: sel.sop, eop: sel.eop};
      end
      // Retirement is tied to eop alone; a no-writeback instruction still retires.
      if (retire_valid_d) begin
         retire_wid_d = sel.wid;
         retire_cnt_d = popcount(sel.tmask);
         instret_d    = instret_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: the held datapath fields are reset too, so wb_* read as zero after reset.
      if (reset) begin
         wb_valid_q     <= 1'b0;
         wb_out_q       <= '0;
         retire_valid_q <= 1'b0;
         retire_wid_q   <= '0;
         retire_cnt_q   <= '0;
         instret_q      <= '0;
      end else begin
         wb_valid_q     <= wb_valid_d;
         wb_out_q       <= wb_out_d;
         retire_valid_q <= retire_valid_d;
         retire_wid_q   <= retire_wid_d;
         retire_cnt_q   <= retire_cnt_d;
         instret_q      <= instret_d;
      end
   end

   assign wb_valid     = wb_valid_q;
   assign wb_wid       = wb_out_q.wid;
   assign wb_tmask     = wb_out_q.tmask;
   assign wb_PC        = wb_out_q.pc;
   assign wb_rd        = wb_out_q.rd;
   assign wb_data      = wb_out_q.data;
   assign wb_sop       = wb_out_q.sop;
   assign wb_eop       = wb_out_q.eop;
   assign retire_valid = retire_valid_q;
   assign retire_wid   = retire_wid_q;
   assign retire_cnt   = retire_cnt_q;
   assign instret      = instret_q;

   // Master protocol: a fresh grant must start an instruction, the locked owner must continue one.
   a_sop_protocol: assert property (@(posedge clk) disable iff (reset)
      fire |-> (locked ? !sel.sop : sel.sop));

endmodule

// File: tb/tb_vx_commit_collector.sv
// Directed plus randomized bench for vx_commit_collector against a transaction-level model.
module tb_vx_commit_collector;
   import vx_commit_collector_pkg::*;

   localparam int NU = CC_NUM_UNITS;
   localparam int NT = CC_NUM_THREADS;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [NU-1:0]          in_valid;
   logic [NU*PKT_W-1:0]    in_pkt;
   logic [NU-1:0]          in_ready;
   logic                   wb_valid;
   logic [CC_NW_BITS-1:0]  wb_wid;
   logic [NT-1:0]          wb_tmask;
   logic [CC_PC_BITS-1:0]  wb_PC;
   logic [4:0]             wb_rd;
   logic [NT*CC_XLEN-1:0]  wb_data;
   logic                   wb_sop, wb_eop;
   logic                   retire_valid;
   logic [CC_NW_BITS-1:0]  retire_wid;
   logic [CC_CNT_W-1:0]    retire_cnt;
   logic [INSTRET_W-1:0]   instret;

   always #5 clk = ~clk;

   vx_commit_collector dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_pkt(in_pkt), .in_ready(in_ready),
      .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_tmask(wb_tmask), .wb_PC(wb_PC), .wb_rd(wb_rd),
      .wb_data(wb_data), .wb_sop(wb_sop), .wb_eop(wb_eop), .retire_valid(retire_valid),
      .retire_wid(retire_wid), .retire_cnt(retire_cnt), .instret(instret)
   );

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: transaction-level view of arbitration, lock ownership and outputs.
   int                   m_ptr, m_owner;
   logic [63:0]          m_instret;
   logic                 m_wb_valid, m_ret_valid;
   commit_pkt_t          m_wb;
   logic [CC_NW_BITS-1:0] m_ret_wid;
   logic [CC_CNT_W-1:0]  m_ret_cnt;

   logic [NU-1:0]        drv_valid;
   commit_pkt_t          drv_pkt [NU];
   int                   last_grant;
   logic [NU-1:0]        obs_ready;
   int                   dut_retires = 0;

   function automatic void model_reset();
      m_ptr = 0; m_owner = -1; m_instret = '0;
      m_wb_valid = 1'b0; m_ret_valid = 1'b0; m_wb = '0;
      m_ret_wid = '0; m_ret_cnt = '0;
   endfunction

   function automatic int model_grant(input logic [NU-1:0] v);
      if (m_owner >= 0) return v[m_owner] ? m_owner : -1;
      for (int k = 0; k < NU; k++) if (v[(m_ptr + k) % NU]) return (m_ptr + k) % NU;
      return -1;
   endfunction

   function automatic commit_pkt_t mk(input logic sop, input logic eop, input logic wb,
                                      input logic [NT-1:0] tmask);
      commit_pkt_t p;
      p.wid   = CC_NW_BITS'($urandom);
      p.tmask = tmask;
      p.pc    = $urandom;
      p.wb    = wb;
      p.rd    = 5'($urandom);
      for (int t = 0; t < NT; t++) p.data[t*CC_XLEN +: CC_XLEN] = $urandom;
      p.sop   = sop;
      p.eop   = eop;
      return p;
   endfunction

   task automatic check_outputs();
      check("wb_valid", wb_valid, m_wb_valid);
      check("retire_valid", retire_valid, m_ret_valid);
      check("instret", instret, m_instret);
      check("wb_ctrl", {wb_wid, wb_tmask, wb_PC, wb_rd, wb_sop, wb_eop},
            {m_wb.wid, m_wb.tmask, m_wb.pc, m_wb.rd, m_wb.sop, m_wb.eop});
      check("wb_data", wb_data, m_wb.data);
      if (m_ret_valid) check("retire_info", {retire_wid, retire_cnt}, {m_ret_wid, m_ret_cnt});
   endtask

   task automatic cycle();
      int          g;
      commit_pkt_t p;
      @(negedge clk);
      in_valid = drv_valid;
      for (int u = 0; u < NU; u++) in_pkt[u*PKT_W +: PKT_W] = drv_pkt[u];
      #1;
      g = model_grant(drv_valid);
      obs_ready = in_ready;
      check("in_ready", in_ready, (g >= 0) ? (128'(1) << g) : 128'(0));
      @(posedge clk);
      #1;
      m_wb_valid = 1'b0;
      m_ret_valid = 1'b0;
      if (g >= 0) begin
         p = drv_pkt[g];
         if (p.wb) begin
            m_wb_valid = 1'b1;
            m_wb = p;
         end
         if (p.eop) begin
            m_ret_valid = 1'b1;
            m_ret_wid = p.wid;
            m_ret_cnt = CC_CNT_W'($countones(p.tmask));
            m_instret = m_instret + 64'd1;
            m_ptr = (g + 1) % NU;
            m_owner = -1;
         end else begin
            m_owner = g;
         end
      end
      last_grant = g;
      if (retire_valid === 1'b1) dut_retires++;
      check_outputs();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      drv_valid = '1;
      in_valid = '1;
      for (int u = 0; u < NU; u++) in_pkt[u*PKT_W +: PKT_W] = mk(1'b1, 1'b1, 1'b1, NT'($urandom));
      #1;
      check("ready_in_reset", in_ready, 0);
      @(posedge clk);
      #1;
      model_reset();
      check("rst_wb_valid", wb_valid, 0);
      check("rst_instret", instret, 0);
      check("rst_retire_cnt", retire_cnt, 0);
      check_outputs();
      @(negedge clk);
      reset = 1'b0;
      drv_valid = '0;
      in_valid = '0;
   endtask

   task automatic fill(input logic [NT-1:0] tmask);
      for (int u = 0; u < NU; u++) drv_pkt[u] = mk(1'b1, 1'b1, 1'b1, tmask);
   endtask

   int          ins_len [NU];
   int          ins_pos [NU];
   int          exp_seq [4] = '{0, 3, 0, 3};
   int          ret_mark;
   logic [63:0] ins_mark;

   initial begin
      reset = 1'b1;
      in_valid = '0;
      in_pkt = '0;
      drv_valid = '0;
      model_reset();
      do_reset();

      // Two single-packet streams alternate under round-robin.
      drv_valid = 5'b01001;
      for (int c = 0; c < 4; c++) begin
         fill(NT'($urandom));
         cycle();
         check("rr_alternate", obs_ready, 128'(1) << exp_seq[c]);
         check("rr_wb_valid", wb_valid, 1);
      end
      check("rr_instret", instret, 4);

      // Multi-packet instruction from unit 1 with an idle gap blocks unit 2.
      ret_mark = dut_retires;
      fill(NT'($urandom));
      drv_pkt[1] = mk(1'b1, 1'b0, 1'b1, 4'b1111);
      drv_valid = 5'b00110;
      cycle();
      check("lock_first", obs_ready, 5'b00010);
      drv_valid = 5'b00100;
      cycle();
      check("lock_idle_block", obs_ready, 5'b00000);
      drv_pkt[1] = mk(1'b0, 1'b1, 1'b1, 4'b0111);
      drv_valid = 5'b00110;
      cycle();
      check("lock_eop", obs_ready, 5'b00010);
      check("lock_retire_cnt", retire_cnt, 3);
      check("lock_one_retire", dut_retires - ret_mark, 1);
      drv_valid = 5'b00100;
      cycle();
      check("lock_release", obs_ready, 5'b00100);
      check("lock_instret", instret, 6);

      // No-writeback eop still retires.
      drv_valid = 5'b00001;
      drv_pkt[0] = mk(1'b1, 1'b1, 1'b0, 4'b1011);
      cycle();
      check("nowb_wb_valid", wb_valid, 0);
      check("nowb_retire", retire_valid, 1);
      check("nowb_cnt", retire_cnt, 3);

      // Empty lane mask still retires with a zero count.
      ins_mark = instret;
      drv_pkt[0] = mk(1'b1, 1'b1, 1'b1, 4'b0000);
      cycle();
      check("zmask_retire", retire_valid, 1);
      check("zmask_cnt", retire_cnt, 0);
      check("zmask_instret", instret, ins_mark + 64'd1);

      // Reset while unit 4 holds the lock discards the instruction.
      drv_valid = 5'b10000;
      drv_pkt[4] = mk(1'b1, 1'b0, 1'b1, 4'b1100);
      cycle();
      do_reset();
      drv_valid = '1;
      fill(NT'($urandom));
      cycle();
      check("post_reset_grant", obs_ready, 5'b00001);

      // instret wraps at 2^64.
      @(negedge clk);
      drv_valid = '0;
      in_valid = '0;
      force dut.instret_q = '1;
      @(negedge clk);
      release dut.instret_q;
      m_instret = '1;
      m_wb_valid = 1'b0;
      m_ret_valid = 1'b0;
      check("instret_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
      drv_valid = 5'b00100;
      fill(4'b0001);
      cycle();
      check("instret_wrap", instret, 0);

      // Randomized protocol-legal traffic.
      do_reset();
      for (int u = 0; u < NU; u++) begin
         ins_len[u] = 0;
         ins_pos[u] = 0;
      end
      for (int c = 0; c < 600; c++) begin
         for (int u = 0; u < NU; u++) begin
            if (ins_len[u] == 0) ins_len[u] = int'($urandom_range(1, 3));
            drv_pkt[u] = mk(ins_pos[u] == 0, ins_pos[u] == ins_len[u] - 1,
                            $urandom_range(0, 3) != 0, NT'($urandom));
            drv_valid[u] = $urandom_range(0, 9) < 7;
         end
         cycle();
         if (last_grant >= 0) begin
            ins_pos[last_grant]++;
            if (ins_pos[last_grant] == ins_len[last_grant]) begin
               ins_pos[last_grant] = 0;
               ins_len[last_grant] = 0;
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/vx_commit_collector.md
Name: vx_commit_collector

Overview:
- Slave end of the per-issue-slot commit protocol that every execute unit (ALU, LSU, FPU, TCU, SFU) drives as master.
- Arbitrates the NUM_UNITS unit commit streams for one issue slot and emits a single registered writeback stream toward the register file and scoreboard.
- Also emits per-instruction retire events and keeps the slot's 64-bit instret count.
- Instantiated ISSUE_WIDTH times in the core.

Parameters:
- NUM_UNITS, 5, number of execute units feeding this slot
- NUM_THREADS, 4, lanes per warp
- XLEN, 32, register data width
- NW_BITS, 2, warp-id width
- PC_BITS, 32, PC width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  NUM_UNITS  per-unit commit valid
- in_pkt  in  NUM_UNITS*PKT_W  per-unit commit packet. Unit i occupies bits [i*PKT_W +: PKT_W]. Field order MSB→LSB: wid, tmask, PC, wb, rd[4:0], data[NUM_THREADS*XLEN], sop, eop.
- in_ready  out  NUM_UNITS  per-unit accept
- wb_valid  out  1  registered writeback valid
- wb_wid  out  NW_BITS  writeback warp
- wb_tmask  out  NUM_THREADS  writeback lane mask
- wb_PC  out  PC_BITS  writeback PC
- wb_rd  out  5  destination register
- wb_data  out  NUM_THREADS*XLEN  lane data
- wb_sop  out  1  first packet of instruction
- wb_eop  out  1  last packet of instruction
- retire_valid  out  1  one instruction retired this cycle
- retire_wid  out  NW_BITS  warp of retired instruction
- retire_cnt  out  log2(NUM_THREADS)+1  popcount of retired tmask
- instret  out  64  retired-instruction count

Behaviour:
- Downstream has no backpressure. Acceptance (handshake) for unit i = in_valid[i] & in_ready[i].
- Arbitration:
  - Round-robin over in_valid, starting at pointer rr_ptr.
  - Exactly one in_ready bit is high, and only when that unit is valid.
  - in_ready is combinational from in_valid, rr_ptr and the lock state.
- Lock rules:
  - Accepting a packet with sop=1, eop=0 locks the grant to that unit until its eop packet is accepted.
  - While locked, other units get in_ready=0 even if the locked unit drops valid; idle cycles are allowed mid-instruction.
  - A sop=1, eop=1 packet never locks.
- rr_ptr update:
  - On acceptance of an eop packet from unit g, rr_ptr ← (g+1) mod NUM_UNITS.
  - Otherwise rr_ptr is unchanged.
- Latency: one cycle. A packet accepted in cycle N appears on wb_* in cycle N+1.
- wb_valid:
  - wb_valid = accepted & pkt.wb, so packets with wb=0 produce no writeback.
  - wb_* fields hold their last value when wb_valid=0.
- Retire:
  - retire_valid is asserted in cycle N+1 for every accepted eop packet, regardless of the wb bit.
  - retire_wid = pkt.wid; retire_cnt = popcount(pkt.tmask).
  - tmask=0 on an eop packet still retires, with retire_cnt=0.
- instret:
  - Increments by 1 in the same cycle retire_valid is high, i.e. instret is registered alongside retire_valid.
  - Wraps modulo 2^64.
- Reset:
  - wb_valid=0, retire_valid=0, retire_cnt=0, instret=0, rr_ptr=0, lock cleared; all wb_* data fields=0.
  - in_ready=0 during reset.
  - Reset mid-instruction discards the partial instruction; no retire is generated.
- Simultaneous events:
  - With all units valid and no lock, the grant is the first valid unit at or after rr_ptr.
  - A single-packet grant and its pointer update happen in the same cycle.
- Protocol errors (simulation assertions only; hardware behaviour unspecified):
  - sop=0 arriving from an unlocked unit.
  - sop=1 arriving from the locked unit.

Decomposition:
- Shared package holds:
  - commit_pkt_t typedef and PKT_W = NW_BITS+NUM_THREADS+PC_BITS+1+5+NUM_THREADS*XLEN+2.
  - The instret width constant.
- One sub-module: vx_rr_lock_arbiter (NUM_UNITS requests, lock/unlock inputs, one-hot grant, rr_ptr state).
- Output registers, popcount and instret counter live in the top module.

Test Plan:
- Units 0 and 3 each present one sop=eop=1 packet every cycle for 4 cycles, rr_ptr=0 → grants 0,3,0,3. wb_valid high each cycle from cycle 1, retire_valid ×4, instret=4.
- Unit 1 presents sop=1,eop=0; then an idle cycle (valid=0); then sop=0,eop=1, while unit 2 is valid throughout → unit 2 gets in_ready=0 until unit 1's eop is accepted. Unit 2 is granted the next cycle. Exactly one retire for unit 1.
- Packet with wb=0, eop=1, tmask=4'b1011 → wb_valid=0, retire_valid=1, retire_cnt=3.
- Packet with tmask=0, eop=1 → retire_valid=1, retire_cnt=0, instret +1.
- Assert reset while unit 4 is locked mid-instruction → next cycle in_ready=0, wb_valid=0, instret=0. After reset, unit 0 is granted first when all units are valid.
- Preload instret to 2^64−1 via force, then retire one instruction → instret=0 with no X.
